barker13_detector: RTL

Sliding-window Barker-13 sync detector that sits directly downstream of the hard-decision chip stage. It consumes one hard chip per accepted beat on a 1-bit AXI-Stream slave (`axis_1bit.slave`). It produces one flag beat per input chip on a 1-bit AXI-Stream master (`axis_1bit.master`), marking where a full Barker-13 word of either polarity ends. The block correlates against a fixed code and registers its output through a single pipeline stage with AXIS back-pressure.

---
 rtl/barker13_detector_if.sv | 30 +++
 rtl/barker13_detector.sv | 96 +++++++++
 2 files changed

// File: rtl/barker13_detector_if.sv
`default_nettype none
// ============================================================================
// Interface : axis_1bit
// Purpose   : Single-bit AXI-Stream link with tlast and a 1-bit tuser.
// Revision  : 1.0 - initial release
// ============================================================================
interface axis_1bit;
  logic tvalid;
  logic tready;
  logic tdata;
  logic tlast;
  logic tuser;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface : axis_1bit
`default_nettype wire

// File: rtl/barker13_detector.sv
`default_nettype none
// ============================================================================
// Module   : barker13_detector
// Purpose  : Sliding-window Barker-13 correlator on a 1-bit chip stream, with
//            one registered flag beat per chip (either code polarity).
// Revision : 1.0 - initial release
// ============================================================================
module barker13_detector #(
  parameter int THRESHOLD = 12
) (
  input  wire logic clk,
  input  wire logic rst_n,
  axis_1bit.slave   s,
  axis_1bit.master  m
);

  localparam logic [12:0] C_CODE   = 13'b1111100110101;
  localparam logic [3:0]  C_FULL   = 4'd13;
  localparam logic [3:0]  C_POS_TH = 4'(THRESHOLD);
  localparam logic [3:0]  C_INV_TH = 4'(13 - THRESHOLD);

  logic [12:0] r_sr;
  logic [3:0]  r_fill;
  logic        r_valid;
  logic        r_data;
  logic        r_user;
  logic        r_last;

  logic        w_accept;
  logic [12:0] w_sr_next;
  logic [3:0]  w_fill_next;
  logic [12:0] w_agree;
  logic [3:0]  w_matches;
  logic        w_window;
  logic        w_pos;
  logic        w_inv;
  logic        w_unused;

  assign s.tready  = !r_valid || m.tready;
  assign w_accept  = s.tvalid && s.tready;
  assign w_unused  = s.tuser;

  assign w_sr_next   = {r_sr[11:0], s.tdata};
  assign w_fill_next = (r_fill == C_FULL) ? C_FULL : r_fill + 4'd1;
  assign w_agree     = ~(w_sr_next ^ C_CODE);

  always_comb begin
    w_matches = 4'd0;
    for (int i = 0; i < 13; i++) begin
      w_matches = w_matches + {3'b000, w_agree[i]};
    end
  end

  assign w_window = (w_fill_next == C_FULL);
  assign w_pos    = w_window && (w_matches >= C_POS_TH);
  assign w_inv    = w_window && (w_matches <= C_INV_TH);

  // A tlast beat is correlated with its own chip, then the window restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= 13'd0;
      r_fill <= 4'd0;
    end else if (w_accept) begin
      if (s.tlast) begin
        r_sr   <= 13'd0;
        r_fill <= 4'd0;
      end else begin
        r_sr   <= w_sr_next;
        r_fill <= w_fill_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= 1'b0;
      r_user  <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_pos || w_inv;
      r_user  <= w_inv && !w_pos;
      r_last  <= s.tlast;
    end else if (m.tready) begin
      r_valid <= 1'b0;
    end
  end

  assign m.tvalid = r_valid;
  assign m.tdata  = r_data;
  assign m.tuser  = r_user;
  assign m.tlast  = r_last;

endmodule : barker13_detector
`default_nettype wire
